lfsr_rng_gen: RTL and testbench

LFSR_RNG_GEN -- requirements
Module: lfsr_rng_gen

---
 rtl/lfsr_rng_gen.sv | 114 +++++++++++
 tb/tb_lfsr_rng_gen.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_rng_gen.sv
// +----------------------------------------------------------------------+
// | lfsr_rng_gen: Fibonacci LFSR random-word source, valid/ready output  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module lfsr_rng_gen #(
  parameter int          WIDTH = 16,
  parameter int          OUT_W = 8,
  parameter int unsigned SEED  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             rd_ready,
  output logic             rd_valid,
  output logic [OUT_W-1:0] random_num,
  output logic             lock_err,
  output logic             period_wrap
);

  generate
    if (!(WIDTH == 8 || WIDTH == 16 || WIDTH == 32)) begin : g_bad_width
      $error("lfsr_rng_gen: WIDTH must be 8, 16 or 32");
    end
    if (OUT_W < 1 || OUT_W > WIDTH) begin : g_bad_out_w
      $error("lfsr_rng_gen: OUT_W must be in 1..WIDTH");
    end
  endgenerate

  localparam logic [31:0]      c_taps_32 = (WIDTH == 8)  ? 32'h0000_00B8 :
                                           (WIDTH == 16) ? 32'h0000_B400 :
                                                           32'h8020_0003;
  localparam logic [WIDTH-1:0] c_taps    = c_taps_32[WIDTH-1:0];
  localparam logic [WIDTH-1:0] c_one     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [31:0]      c_seed_32 = SEED;
  localparam logic [WIDTH-1:0] c_seed_tr = c_seed_32[WIDTH-1:0];
  // A seed whose low WIDTH bits are all zero would lock the LFSR up.
  localparam logic [WIDTH-1:0] c_seed    = (c_seed_tr == '0) ? c_one : c_seed_tr;

  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] start_seed_q, start_seed_d;
  logic [OUT_W-1:0] random_num_q, random_num_d;
  logic             rd_valid_q, rd_valid_d;
  logic             lock_err_q, lock_err_d;
  logic             period_wrap_q, period_wrap_d;

  logic [WIDTH-1:0] lfsr_next;
  logic             slot_free;

  assign lfsr_next = {lfsr_q[WIDTH-2:0], ^(lfsr_q & c_taps)};
  assign slot_free = !rd_valid_q || rd_ready;

  always_comb begin
    lfsr_d        = lfsr_q;
    start_seed_d  = start_seed_q;
    random_num_d  = random_num_q;
    rd_valid_d    = rd_valid_q;
    lock_err_d    = 1'b0;
    period_wrap_d = 1'b0;

    if (seed_load) begin
      // Any handshake in flight this cycle is treated as completed.
      rd_valid_d = 1'b0;
      if (seed_in == '0) begin
        lfsr_d       = c_one;
        start_seed_d = c_one;
        lock_err_d   = 1'b1;
      end else begin
        lfsr_d       = seed_in;
        start_seed_d = seed_in;
      end
    end else if (lfsr_q == '0) begin
      lfsr_d     = c_one;
      lock_err_d = 1'b1;
      rd_valid_d = rd_valid_q && !rd_ready;
    end else if (en && slot_free) begin
      random_num_d  = lfsr_q[OUT_W-1:0];
      rd_valid_d    = 1'b1;
      lfsr_d        = lfsr_next;
      period_wrap_d = (lfsr_next == start_seed_q);
    end else if (rd_valid_q && rd_ready) begin
      rd_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      lfsr_q        <= c_seed;
      start_seed_q  <= c_seed;
      random_num_q  <= '0;
      rd_valid_q    <= 1'b0;
      lock_err_q    <= 1'b0;
      period_wrap_q <= 1'b0;
    end else begin
      lfsr_q        <= lfsr_d;
      start_seed_q  <= start_seed_d;
      random_num_q  <= random_num_d;
      rd_valid_q    <= rd_valid_d;
      lock_err_q    <= lock_err_d;
      period_wrap_q <= period_wrap_d;
    end
  end

  assign rd_valid    = rd_valid_q;
  assign random_num  = random_num_q;
  assign lock_err    = lock_err_q;
  assign period_wrap = period_wrap_q;

endmodule

`default_nettype wire

// File: tb/tb_lfsr_rng_gen.sv
// +----------------------------------------------------------------------+
// | tb_lfsr_rng_gen: checks 8-bit and 16-bit LFSR generators             |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_lfsr_rng_gen;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, en, seed_load, rd_ready;
  logic [7:0]  seed_in8;
  logic [15:0] seed_in16;
  logic        v8, le8, pw8, v16, le16, pw16;
  logic [7:0]  n8, n16;

  lfsr_rng_gen #(.WIDTH(8), .OUT_W(8), .SEED(1)) u_dut8 (
    .clk(clk), .reset(reset), .en(en), .seed_load(seed_load), .seed_in(seed_in8),
    .rd_ready(rd_ready), .rd_valid(v8), .random_num(n8), .lock_err(le8),
    .period_wrap(pw8)
  );

  lfsr_rng_gen #(.WIDTH(16), .OUT_W(8), .SEED(1)) u_dut16 (
    .clk(clk), .reset(reset), .en(en), .seed_load(seed_load), .seed_in(seed_in16),
    .rd_ready(rd_ready), .rd_valid(v16), .random_num(n16), .lock_err(le16),
    .period_wrap(pw16)
  );

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Reference state per generator: index 0 = 8-bit, index 1 = 16-bit.
  int unsigned m_lfsr[2], m_start[2], m_num[2];
  bit          m_valid[2], m_lock[2], m_wrap[2];

  function automatic int unsigned lfsr_step(input int w, input int unsigned s);
    int taps[4];
    int unsigned fb = 0;
    if (w == 8) taps = '{7, 5, 4, 3};
    else        taps = '{15, 13, 12, 10};
    foreach (taps[i]) fb ^= (s >> taps[i]) & 1;
    return ((s << 1) | fb) & ((32'd1 << w) - 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      int w = (k == 0) ? 8 : 16;
      int unsigned s;
      bit free;
      if (!reset) begin
        m_lfsr[k] = 1; m_start[k] = 1; m_num[k] = 0;
        m_valid[k] = 0; m_lock[k] = 0; m_wrap[k] = 0;
      end else begin
        free = !m_valid[k] || rd_ready;
        m_lock[k] = 0;
        m_wrap[k] = 0;
        if (seed_load) begin
          s = (k == 0) ? 32'(seed_in8) : 32'(seed_in16);
          if (s == 0) begin
            s = 1;
            m_lock[k] = 1;
          end
          m_lfsr[k]  = s;
          m_start[k] = s;
          m_valid[k] = 0;
        end else if (en && free) begin
          m_num[k]   = m_lfsr[k] & 32'hFF;
          m_valid[k] = 1;
          m_lfsr[k]  = lfsr_step(w, m_lfsr[k]);
          m_wrap[k]  = (m_lfsr[k] == m_start[k]);
        end else if (m_valid[k] && rd_ready) begin
          m_valid[k] = 0;
        end
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check("valid8", 32'(v8),   32'(m_valid[0]));
    check("num8",   32'(n8),   m_num[0]);
    check("lock8",  32'(le8),  32'(m_lock[0]));
    check("wrap8",  32'(pw8),  32'(m_wrap[0]));
    check("valid16", 32'(v16),  32'(m_valid[1]));
    check("num16",   32'(n16),  m_num[1]);
    check("lock16",  32'(le16), 32'(m_lock[1]));
    check("wrap16",  32'(pw16), 32'(m_wrap[1]));
  endtask

  initial begin
    logic [7:0] exp_seq [6];
    bit         seen [256];
    int         distinct;
    int         wraps;

    exp_seq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23};
    reset = 1'b0; en = 1'b0; seed_load = 1'b0; rd_ready = 1'b0;
    seed_in8 = '0; seed_in16 = '0;

    // Reset state.
    tick(); tick();
    check("rst_valid8", 32'(v8), 32'd0);
    check("rst_num8",   32'(n8), 32'd0);

    // Free-running stream from reset.
    reset = 1'b1; en = 1'b1; rd_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("seq8", 32'(n8), 32'(exp_seq[i]));
      check("seq8_valid", 32'(v8), 32'd1);
    end

    // Backpressure: word held, nothing skipped.
    reset = 1'b0; tick();
    reset = 1'b1; rd_ready = 1'b0; tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall8", 32'(n8), 32'h01);
    end
    rd_ready = 1'b1; tick();
    check("resume8_a", 32'(n8), 32'h02);
    tick();
    check("resume8_b", 32'(n8), 32'h04);

    // Full period from seed 1.
    reset = 1'b0; tick();
    reset = 1'b1;
    foreach (seen[i]) seen[i] = 1'b0;
    distinct = 0;
    wraps = 0;
    for (int i = 1; i <= 255; i++) begin
      tick();
      if (!seen[n8]) distinct++;
      seen[n8] = 1'b1;
      if (pw8) wraps++;
    end
    check("period_distinct", 32'(distinct), 32'd255);
    check("period_nozero", 32'(seen[0]), 32'd0);
    check("period_wrap_last", 32'(pw8), 32'd1);
    check("period_wrap_count", 32'(wraps), 32'd1);
    tick();
    check("period_wrap_drop", 32'(pw8), 32'd0);

    // Zero seed replaced by 1.
    seed_load = 1'b1; seed_in8 = 8'h00; seed_in16 = 16'h0000; tick();
    check("zseed_valid8", 32'(v8), 32'd0);
    check("zseed_lock8", 32'(le8), 32'd1);
    seed_load = 1'b0; tick();
    check("zseed_lock8_off", 32'(le8), 32'd0);
    check("zseed_first8", 32'(n8), 32'h01);
    check("zseed_first16", 32'(n16), 32'h01);

    // Seed load while stalled on a valid word.
    rd_ready = 1'b0; tick();
    seed_load = 1'b1; seed_in16 = 16'hACE1; seed_in8 = 8'h5A; tick();
    check("ld16_valid_drop", 32'(v16), 32'd0);
    seed_load = 1'b0; tick();
    check("ld16_first", 32'(n16), 32'hE1);
    rd_ready = 1'b1; tick();
    // Tap XOR of 0xACE1 is 1, so the advanced value is 0x59C3.
    check("ld16_second", 32'(n16), lfsr_step(16, 32'hACE1) & 32'hFF);

    // Mid-stream reset discards the pending word.
    tick(); tick();
    reset = 1'b0; tick();
    check("mrst_valid8", 32'(v8), 32'd0);
    check("mrst_num8",   32'(n8), 32'd0);
    reset = 1'b1; tick();
    check("mrst_first8",  32'(n8),  32'h01);
    check("mrst_first16", 32'(n16), 32'h01);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      en        = 1'($urandom_range(0, 3) != 0);
      rd_ready  = 1'($urandom_range(0, 2) != 0);
      seed_load = 1'($urandom_range(0, 15) == 0);
      seed_in8  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      seed_in16 = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      reset     = 1'($urandom_range(0, 63) != 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
